// File: rtl/ecg_synth_if.sv
// Purpose : control/sample bundle between the ECG synthesiser and its user.
// Ports   : enable/bpm_set/bpm_load in; bpm_ack/busy/Xout/beat_start/r_peak/rr_cycles out.
// master = rate/enable driver (e.g. self-test controller), slave = ecg_synth.
interface ecg_synth_if;
    logic              enable;
    logic [7:0]        bpm_set;
    logic              bpm_load;
    logic              bpm_ack;
    logic              busy;
    logic signed [7:0] Xout;
    logic              beat_start;
    logic              r_peak;
    logic [31:0]       rr_cycles;

    modport master (
        output enable, bpm_set, bpm_load,
        input  bpm_ack, busy, Xout, beat_start, r_peak, rr_cycles
    );

    modport slave (
        input  enable, bpm_set, bpm_load,
        output bpm_ack, busy, Xout, beat_start, r_peak, rr_cycles
    );
endinterface

// File: rtl/ecg_synth.sv
// Purpose : synthetic P-QRS-T ECG source, one registered sample per clk at a programmable bpm.
// Latency : Xout/beat_start/r_peak registered, 1 cycle after the beat index; bpm_load -> period 33 cycles + next wrap.
// Backpressure: none on samples; bpm_load is dropped (no ack) while the period divider is busy.
// Ports   : clk, rst (sync, active-high); bus = ecg_synth_if.slave (enable, bpm_set, bpm_load,
//           bpm_ack, busy, Xout, beat_start, r_peak, rr_cycles).
// Option  : define NOISE_EN to add LFSR dither (-3..+3, saturating) to the template in RUN.
module ecg_synth #(
    parameter int unsigned CLK_FREQ    = 200,
    parameter int unsigned BPM_MIN     = 30,
    parameter int unsigned BPM_MAX     = 180,
    parameter int unsigned BPM_DEFAULT = 60
) (
    input  logic        clk,
    input  logic        rst,
    ecg_synth_if.slave  bus
);
    localparam logic [31:0] NUMER    = 32'(CLK_FREQ * 60);
    localparam logic [31:0] RR_RESET = 32'(CLK_FREQ * 60 / BPM_DEFAULT);
    localparam logic [7:0]  BMIN     = 8'(BPM_MIN);
    localparam logic [7:0]  BMAX     = 8'(BPM_MAX);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       rr_q, rr_d;
    logic [31:0]       pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic signed [7:0] xout_q, xout_d;
    logic              beat_q, beat_d;
    logic              rpk_q, rpk_d;

    logic              busy_q, busy_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        dvsr_q, dvsr_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       rem_q, rem_d;
    logic [32:0]       rem_sh;
    logic              accept;
    logic              div_done;
    logic              wrap;
    logic signed [7:0] tmpl_v;
    logic signed [7:0] samp_v;

    // Beat template; everything outside the listed indices (and n >= 60) is baseline.
    function automatic logic signed [7:0] tmpl(input logic [31:0] n);
        logic signed [7:0] v;
        v = '0;
        if (n < 32'd60) begin
            case (n[5:0])
                6'd0,  6'd10, 6'd40, 6'd58: v = 8'sd2;
                6'd1,  6'd9,  6'd41, 6'd57: v = 8'sd4;
                6'd2,  6'd8,  6'd42, 6'd56: v = 8'sd6;
                6'd3,  6'd7,  6'd43, 6'd55: v = 8'sd8;
                6'd4,  6'd6,  6'd44, 6'd54: v = 8'sd10;
                6'd5,  6'd45, 6'd53:        v = 8'sd12;
                6'd46, 6'd52:               v = 8'sd14;
                6'd47, 6'd51:               v = 8'sd16;
                6'd48, 6'd50:               v = 8'sd18;
                6'd49:                      v = 8'sd20;
                6'd18, 6'd24:               v = 8'sd24;
                6'd19, 6'd23:               v = 8'sd48;
                6'd20, 6'd22:               v = 8'sd72;
                6'd21:                      v = 8'sd96;
                6'd26, 6'd28:               v = -8'sd12;
                6'd27:                      v = -8'sd24;
                default:                    v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [7:0] clamp_bpm(input logic [7:0] b);
        if (b < BMIN) return BMIN;
        if (b > BMAX) return BMAX;
        return b;
    endfunction

    assign tmpl_v = tmpl(n_q);

`ifdef NOISE_EN
    logic [15:0]       lfsr_q, lfsr_d;
    logic signed [3:0] noise;
    logic signed [9:0] sum;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        // 0..6 -> -3..+3; 7 folds onto zero so the dither stays symmetric
        noise = (lfsr_q[2:0] == 3'd7) ? 4'sd0 : ($signed({1'b0, lfsr_q[2:0]}) - 4'sd3);
        sum   = $signed({{2{tmpl_v[7]}}, tmpl_v}) + $signed({{6{noise[3]}}, noise});
        if (sum > 10'sd127) begin
            samp_v = 8'sd127;
        end else if (sum < -10'sd128) begin
            samp_v = -8'sd128;
        end else begin
            samp_v = sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign samp_v = tmpl_v;
`endif

    // Restoring divider: one quotient bit per cycle, 32 cycles, NUMER / clamped bpm.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        dvsr_d   = dvsr_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_done = 1'b0;
        accept   = bus.bpm_load && !busy_q;
        rem_sh   = {rem_q, quo_q[31]};
        if (accept) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            dvsr_d = clamp_bpm(bus.bpm_set);
            quo_d  = NUMER;
            rem_d  = '0;
        end else if (busy_q) begin
            if (rem_sh >= {25'd0, dvsr_q}) begin
                rem_d = 32'(rem_sh - {25'd0, dvsr_q});
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_sh[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d   = 1'b0;
                div_done = 1'b1;
            end
        end
    end

    // Beat sequencer; a new period only takes effect at a beat boundary or while idle.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rr_d       = rr_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        xout_d     = '0;
        beat_d     = 1'b0;
        rpk_d      = 1'b0;
        wrap       = (n_q == rr_q - 32'd1);
        case (state_q)
            IDLE: begin
                n_d = '0;
                if (pend_vld_q) begin
                    rr_d       = pend_q;
                    pend_vld_d = 1'b0;
                end
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    n_d     = '0;
                end else begin
                    xout_d = samp_v;
                    beat_d = (n_q == 32'd0);
                    rpk_d  = (n_q == 32'd21);
                    if (wrap) begin
                        n_d = '0;
                        if (pend_vld_q) begin
                            rr_d       = pend_q;
                            pend_vld_d = 1'b0;
                        end
                    end else begin
                        n_d = n_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh quotient always wins over an older unapplied one.
        if (div_done) begin
            pend_d     = quo_d;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rr_q       <= RR_RESET;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            xout_q     <= '0;
            beat_q     <= 1'b0;
            rpk_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            dvsr_q     <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            xout_q     <= xout_d;
            beat_q     <= beat_d;
            rpk_q      <= rpk_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            dvsr_q     <= dvsr_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
        end
    end

    assign bus.bpm_ack    = accept && !rst;
    assign bus.busy       = busy_q;
    assign bus.Xout       = xout_q;
    assign bus.beat_start = beat_q;
    assign bus.r_peak     = rpk_q;
    assign bus.rr_cycles  = rr_q;
endmodule

// File: tb/tb_ecg_synth.sv
// Purpose : scoreboard bench for ecg_synth against a beat/period reference model.
// Latency : model predicts every sample; a monitor compares once per cycle on the falling edge.
// Backpressure: none; the driver issues one input vector per clock.
module tb_ecg_synth;
    localparam int NUM = 200 * 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecg_synth_if bus ();

    ecg_synth dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [7:0] x;
        logic              bs;
        logic              rp;
        logic              busy;
        logic              ack;
        logic [31:0]       rr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // reference model state
    bit                m_run;
    int                m_n;
    int                m_per;
    int                m_pend;   // -1 = nothing pending
    int                m_left;   // divider cycles remaining
    int                m_val;
    logic signed [7:0] m_x;
    bit                m_bs, m_rp;
    logic [15:0]       m_lfsr;

    function automatic int tmpl_ref(input int n);
        if (n < 6)  return 2 * (n + 1);
        if (n < 12) return 2 * (11 - n);
        if (n < 18) return 0;
        if (n < 22) return 24 * (n - 17);
        if (n < 26) return 24 * (25 - n);
        if (n == 26 || n == 28) return -12;
        if (n == 27) return -24;
        if (n < 40) return 0;
        if (n < 50) return 2 * (n - 39);
        if (n < 60) return 2 * (59 - n);
        return 0;
    endfunction

    function automatic int clampi(input int b);
        if (b < 30)  return 30;
        if (b > 180) return 180;
        return b;
    endfunction

    task automatic model_reset();
        m_run = 0; m_n = 0; m_per = NUM / 60; m_pend = -1; m_left = 0; m_val = 0;
        m_x = 0; m_bs = 0; m_rp = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input bit en, input bit ld, input int set, input bit r);
        int  pend_old, per_old, v, fin_val;
        bit  acc, fin, applied, was_run;
        if (r) begin
            model_reset();
            return;
        end
        pend_old = m_pend; per_old = m_per; was_run = m_run;
        acc = ld && (m_left == 0);
        fin = 0; fin_val = 0; applied = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin fin = 1; fin_val = m_val; end
        end
        if (acc) begin m_val = NUM / clampi(set); m_left = 32; end
        m_x = 0; m_bs = 0; m_rp = 0;
        if (!m_run) begin
            if (pend_old >= 0) begin m_per = pend_old; applied = 1; end
            m_n = 0;
            if (en) m_run = 1;
        end else if (!en) begin
            m_run = 0; m_n = 0;
        end else begin
            v = tmpl_ref(m_n);
`ifdef NOISE_EN
            v = v + ((m_lfsr[2:0] == 3'd7) ? 0 : int'(m_lfsr[2:0]) - 3);
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
`endif
            m_x = 8'(v); m_bs = (m_n == 0); m_rp = (m_n == 21);
            if (m_n == per_old - 1) begin
                m_n = 0;
                if (pend_old >= 0) begin m_per = pend_old; applied = 1; end
            end else begin
                m_n++;
            end
        end
        if (was_run) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (applied) m_pend = -1;
        if (fin) m_pend = fin_val;
    endtask

    // Drive one cycle of inputs, queue what the DUT must show before the next edge, then advance.
    task automatic cyc(input bit en, input bit ld, input int set, input bit r);
        exp_t e;
        rst = r; bus.enable = en; bus.bpm_load = ld; bus.bpm_set = 8'(set);
        e.x = m_x; e.bs = m_bs; e.rp = m_rp; e.busy = (m_left > 0);
        e.ack = ld && (m_left == 0) && !r; e.rr = 32'(m_per);
        q.push_back(e);
        @(posedge clk); #1;
        model_step(en, ld, set, r);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.Xout !== e.x || bus.beat_start !== e.bs || bus.r_peak !== e.rp ||
                    bus.busy !== e.busy || bus.bpm_ack !== e.ack || bus.rr_cycles !== e.rr) begin
                    fails++;
                    $display("FAIL sample t=%0t: got x=%0d bs=%0b rp=%0b busy=%0b ack=%0b rr=%0d, expected x=%0d bs=%0b rp=%0b busy=%0b ack=%0b rr=%0d",
                             $time, bus.Xout, bus.beat_start, bus.r_peak, bus.busy, bus.bpm_ack, bus.rr_cycles,
                             e.x, e.bs, e.rp, e.busy, e.ack, e.rr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; bus.enable = 1'b0; bus.bpm_load = 1'b0; bus.bpm_set = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, then free-running default rate
        cyc(0, 0, 0, 0);
        chk("reset_rr", int'(bus.rr_cycles), 200);
        chk("reset_xout", int'(bus.Xout), 0);
        repeat (450) cyc(1, 0, 0, 0);
        chk("default_rr", int'(bus.rr_cycles), 200);

        // mid-beat rate change to 120 bpm
        cyc(1, 1, 120, 0);
        chk("busy_after_load", int'(bus.busy), 1);
        repeat (400) cyc(1, 0, 0, 0);
        chk("rr_120bpm", int'(bus.rr_cycles), 100);

        // clamping at both ends
        cyc(1, 1, 250, 0);
        repeat (34) cyc(1, 0, 0, 0);
        chk("busy_fell", int'(bus.busy), 0);
        cyc(1, 1, 10, 0);
        repeat (500) cyc(1, 0, 0, 0);
        chk("rr_clamp_lo", int'(bus.rr_cycles), 400);

        // load while busy is ignored
        cyc(1, 1, 150, 0);
        repeat (5) cyc(1, 0, 0, 0);
        cyc(1, 1, 60, 0);
        repeat (500) cyc(1, 0, 0, 0);
        chk("rr_first_only", int'(bus.rr_cycles), 80);

        // disable mid-beat at n=30, then resume
        for (int i = 0; i < 200 && m_n != 30; i++) cyc(1, 0, 0, 0);
        chk("reached_n30", m_n, 30);
        repeat (10) cyc(0, 0, 0, 0);
        chk("idle_xout", int'(bus.Xout), 0);
        repeat (100) cyc(1, 0, 0, 0);

        // reset in the middle of a divide
        cyc(1, 1, 120, 0);
        repeat (10) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("rst_busy", int'(bus.busy), 0);
        repeat (300) cyc(1, 0, 0, 0);
        chk("rst_rr", int'(bus.rr_cycles), 200);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 39) == 0,
                int'($urandom_range(0, 255)), $urandom_range(0, 1999) == 0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
